multi_mode_ff_bank: RTL and testbench

//  - WIDTH-channel bank of configurable flip-flops; every channel runs in JK, D, T or SR mode from a shared mode input.
//  - Next generation of the single JK flop: parametrised width, runtime mode, enable, sync clear, illegal-SR detection.
//  - Optional toggle-event counter. Sits in the sequential-primitives library as a building block for counters and state regs.

---
 rtl/mmff_pkg.sv | 21 ++
 rtl/mmff_cell.sv | 64 ++++++
 rtl/multi_mode_ff_bank.sv | 78 +++++++
 tb/tb_multi_mode_ff_bank.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmff_pkg.sv
// rtl/mmff_pkg.sv - mode encodings and popcount helper for the multi-mode flip-flop bank
package mmff_pkg;

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_D  = 2'b01;
    localparam logic [1:0] MODE_T  = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    // Widest bank the popcount helper covers; callers zero-extend into it
    localparam int POP_MAX_W = 64;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mmff_cell.sv
// rtl/mmff_cell.sv - one flip-flop channel with JK/D/T/SR next-state logic and sticky SR-illegal flag
module mmff_cell
    import mmff_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] mode,
    input  logic       j,
    input  logic       k,
    output logic       q_next,
    output logic       q,
    output logic       sr_err
);

    logic sr_hit;

    // Next-state value the channel takes on an enabled edge; sr_hit flags S=R=1 in SR mode
    always_comb begin
        q_next = q;
        sr_hit = 1'b0;
        case (mode)
            MODE_JK: begin
                case ({j, k})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   q_next = ~q;
                    default: q_next = q;
                endcase
            end
            MODE_D: q_next = j;
            MODE_T: q_next = j ? ~q : q;
            default: begin
                case ({j, k})
                    2'b10:   q_next = 1'b1;
                    2'b01:   q_next = 1'b0;
                    2'b11: begin
                        q_next = q;
                        sr_hit = 1'b1;
                    end
                    default: q_next = q;
                endcase
            end
        endcase
    end

    // State and sticky error register: clear beats enable, enable beats hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q      <= 1'b0;
            sr_err <= 1'b0;
        end else if (clr) begin
            q      <= 1'b0;
            sr_err <= 1'b0;
        end else if (en) begin
            q <= q_next;
            if (sr_hit) begin
                sr_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// rtl/multi_mode_ff_bank.sv - WIDTH-channel multi-mode flip-flop bank; MMFF_TOGGLE_CNT_EN adds a saturating toggle counter
module multi_mode_ff_bank
    import mmff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] sr_err,
    output logic [CNT_W-1:0] tog_cnt
);

    logic [WIDTH-1:0] q_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        mmff_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .clr    (clr),
            .mode   (mode),
            .j      (j[i]),
            .k      (k[i]),
            .q_next (q_next[i]),
            .q      (q[i]),
            .sr_err (sr_err[i])
        );
    end

    // qb is derived from q so the two can never disagree
    assign qb = ~q;

`ifdef MMFF_TOGGLE_CNT_EN
    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    logic [POP_MAX_W-1:0] diff_wide;
    logic [PC_W-1:0]      flips;
    logic [SUM_W-1:0]     sum;
    logic [SUM_W-1:0]     sat_max;
    logic [CNT_W-1:0]     cnt;

    // Bits that change on this edge, summed into the counter with headroom to detect overflow
    always_comb begin
        diff_wide = POP_MAX_W'(q_next ^ q);
        flips     = PC_W'(popcount(diff_wide));
        sum       = SUM_W'(cnt) + SUM_W'(flips);
        sat_max   = SUM_W'({CNT_W{1'b1}});
    end

    // Toggle counter: saturates at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (sum > sat_max) ? {CNT_W{1'b1}} : CNT_W'(sum);
        end
    end

    assign tog_cnt = cnt;
`else
    logic unused_q_next;

    assign unused_q_next = ^q_next;
    assign tog_cnt       = '0;
`endif

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// tb/tb_multi_mode_ff_bank.sv - scoreboard bench for multi_mode_ff_bank (tracks MMFF_TOGGLE_CNT_EN)
module tb_multi_mode_ff_bank;

    localparam int W  = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic [W-1:0]  q;
        logic [W-1:0]  qb;
        logic [W-1:0]  err;
        logic [CW-1:0] cnt;
    } snap_t;

    logic          clk;
    logic          rst;
    logic          en;
    logic          clr;
    logic [1:0]    mode;
    logic [W-1:0]  j;
    logic [W-1:0]  k;
    logic [W-1:0]  q;
    logic [W-1:0]  qb;
    logic [W-1:0]  sr_err;
    logic [CW-1:0] tog_cnt;

    int total;
    int bad;

    snap_t exp_q[$];
    snap_t obs_q[$];

    logic [W-1:0] m_q;
    logic [W-1:0] m_err;
    int           m_cnt;

    multi_mode_ff_bank #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .mode    (mode),
        .j       (j),
        .k       (k),
        .q       (q),
        .qb      (qb),
        .sr_err  (sr_err),
        .tog_cnt (tog_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t model_snap();
        snap_t s;
        s.q   = m_q;
        s.qb  = ~m_q;
        s.err = m_err;
`ifdef MMFF_TOGGLE_CNT_EN
        s.cnt = CW'(m_cnt);
`else
        s.cnt = '0;
`endif
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.q   = q;
        s.qb  = qb;
        s.err = sr_err;
        s.cnt = tog_cnt;
        return s;
    endfunction

    // Applies one cycle of stimulus, advances the reference model, records expected and observed
    task automatic drive(input logic e, input logic c, input logic [1:0] m,
                         input logic [W-1:0] jj, input logic [W-1:0] kk);
        logic [W-1:0] nq;
        en = e; clr = c; mode = m; j = jj; k = kk;
        case (m)
            2'b00:   nq = (jj & ~m_q) | (~kk & m_q);
            2'b01:   nq = jj;
            2'b10:   nq = m_q ^ jj;
            default: nq = (jj & ~kk) | (m_q & ~(jj ^ kk));
        endcase
        if (c) begin
            m_q = '0; m_err = '0; m_cnt = 0;
        end else if (e) begin
            m_cnt = m_cnt + $countones(nq ^ m_q);
            if (m_cnt > (1 << CW) - 1) m_cnt = (1 << CW) - 1;
            if (m == 2'b11) m_err = m_err | (jj & kk);
            m_q = nq;
        end
        exp_q.push_back(model_snap());
        @(posedge clk);
        @(negedge clk);
        obs_q.push_back(dut_snap());
    endtask

    task automatic test_reset();
        snap_t o;
        rst = 1'b1; en = 1'b1; clr = 1'b0; mode = 2'b01; j = 8'hFF; k = '0;
        @(negedge clk);
        @(negedge clk);
        o = dut_snap();
        total++;
        if (o !== snap_t'{8'h00, 8'hFF, 8'h00, 4'h0}) begin
            bad++;
            $display("FAIL reset_hold got q=%h qb=%h err=%h cnt=%h want 00 ff 00 0", o.q, o.qb, o.err, o.cnt);
        end
        rst = 1'b0;
        m_q = '0; m_err = '0; m_cnt = 0;
        drive(1'b1, 1'b0, 2'b01, 8'hA5, 8'h00);
        total++;
        if (q !== 8'hA5) begin
            bad++;
            $display("FAIL reset_preload got q=%h want a5", q);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        o = dut_snap();
        total++;
        if (o !== snap_t'{8'h00, 8'hFF, 8'h00, 4'h0}) begin
            bad++;
            $display("FAIL reset_async got q=%h qb=%h err=%h cnt=%h want 00 ff 00 0", o.q, o.qb, o.err, o.cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        m_q = '0; m_err = '0; m_cnt = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_jk();
        snap_t e, o;
        drive(1'b1, 1'b0, 2'b00, 8'hF0, 8'h0F);
        drive(1'b1, 1'b0, 2'b00, 8'hFF, 8'hFF);
        drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h03);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL jk got q=%h qb=%h err=%h cnt=%h want %h %h %h %h", o.q, o.qb, o.err, o.cnt, e.q, e.qb, e.err, e.cnt);
            end
        end
        total++;
        if (q !== 8'h0C) begin
            bad++;
            $display("FAIL jk_final got q=%h want 0c", q);
        end
    endtask

    task automatic test_d_t();
        snap_t e, o;
        drive(1'b1, 1'b0, 2'b01, 8'h3C, 8'hFF);
        repeat (3) drive(1'b1, 1'b0, 2'b10, 8'h01, 8'hA5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL d_t got q=%h qb=%h err=%h cnt=%h want %h %h %h %h", o.q, o.qb, o.err, o.cnt, e.q, e.qb, e.err, e.cnt);
            end
        end
        total++;
        if (q !== 8'h3D) begin
            bad++;
            $display("FAIL d_t_final got q=%h want 3d", q);
        end
    endtask

    task automatic test_sr();
        snap_t e, o;
        drive(1'b1, 1'b1, 2'b11, 8'hFF, 8'hFF);
        drive(1'b1, 1'b0, 2'b11, 8'h81, 8'h01);
        total++;
        if (q !== 8'h80 || sr_err !== 8'h01) begin
            bad++;
            $display("FAIL sr_illegal got q=%h err=%h want 80 01", q, sr_err);
        end
        repeat (5) drive(1'b1, 1'b0, 2'b00, 8'($urandom), 8'($urandom));
        total++;
        if (sr_err !== 8'h01) begin
            bad++;
            $display("FAIL sr_sticky got err=%h want 01", sr_err);
        end
        drive(1'b0, 1'b0, 2'b11, 8'hFF, 8'hFF);
        drive(1'b1, 1'b1, 2'b11, 8'hFF, 8'hFF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL sr got q=%h qb=%h err=%h cnt=%h want %h %h %h %h", o.q, o.qb, o.err, o.cnt, e.q, e.qb, e.err, e.cnt);
            end
        end
    endtask

    task automatic test_hold();
        snap_t e, o;
        drive(1'b1, 1'b0, 2'b01, 8'h5A, 8'h00);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 2'(i), 8'($urandom) | 8'h0F, 8'($urandom) | 8'h0F);
        end
        total++;
        if (q !== 8'h5A || sr_err !== 8'h00) begin
            bad++;
            $display("FAIL hold got q=%h err=%h want 5a 00", q, sr_err);
        end
        drive(1'b1, 1'b1, 2'b00, 8'hFF, 8'hFF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL hold_clr got q=%h qb=%h err=%h cnt=%h want %h %h %h %h", o.q, o.qb, o.err, o.cnt, e.q, e.qb, e.err, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        snap_t e, o;
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                  2'($urandom), 8'($urandom), 8'($urandom));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL b2b got q=%h qb=%h err=%h cnt=%h want %h %h %h %h", o.q, o.qb, o.err, o.cnt, e.q, e.qb, e.err, e.cnt);
            end
        end
    endtask

    task automatic test_saturation();
        snap_t e, o;
        drive(1'b1, 1'b1, 2'b00, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 2'b00, 8'hF0, 8'h0F);
        drive(1'b1, 1'b0, 2'b00, 8'hFF, 8'hFF);
        repeat (3) drive(1'b1, 1'b0, 2'b00, 8'hFF, 8'hFF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL sat got q=%h qb=%h err=%h cnt=%h want %h %h %h %h", o.q, o.qb, o.err, o.cnt, e.q, e.qb, e.err, e.cnt);
            end
        end
`ifdef MMFF_TOGGLE_CNT_EN
        total++;
        if (tog_cnt !== 4'hF) begin
            bad++;
            $display("FAIL sat_final got cnt=%h want f", tog_cnt);
        end
`else
        total++;
        if (tog_cnt !== 4'h0) begin
            bad++;
            $display("FAIL cnt_tied got cnt=%h want 0", tog_cnt);
        end
`endif
    endtask

    initial begin
        total = 0; bad = 0;
        m_q = '0; m_err = '0; m_cnt = 0;
        rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'b00; j = '0; k = '0;
        test_reset();
        test_jk();
        test_d_t();
        test_sr();
        test_hold();
        test_back_to_back();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
